// File: rtl/mii_pcs_pkg.sv
// Shared constants and types for the MII to 64b/66b PCS transmit encoder.
// Holds the transmit state encoding, block classes, sync headers and block-type codes.
package mii_pcs_pkg;

   typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
   typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_e;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam logic [7:0] MII_IDLE  = 8'h07;
   localparam logic [7:0] MII_START = 8'hFB;
   localparam logic [7:0] MII_TERM  = 8'hFD;

   localparam logic [6:0] CODE_IDLE = 7'h00;
   localparam logic [6:0] CODE_ERR  = 7'h1E;

   localparam logic [7:0] BT_CTRL  = 8'h1E;
   localparam logic [7:0] BT_START = 8'h78;
   localparam logic [7:0] BT_T0    = 8'h87;
   localparam logic [7:0] BT_T1    = 8'h99;
   localparam logic [7:0] BT_T2    = 8'hAA;
   localparam logic [7:0] BT_T3    = 8'hB4;
   localparam logic [7:0] BT_T4    = 8'hCC;
   localparam logic [7:0] BT_T5    = 8'hD2;
   localparam logic [7:0] BT_T6    = 8'hE1;
   localparam logic [7:0] BT_T7    = 8'hFF;

   function automatic logic [7:0] term_type(input logic [2:0] k);
      logic [7:0] t;
      unique case (k)
         3'd0:    t = BT_T0;
         3'd1:    t = BT_T1;
         3'd2:    t = BT_T2;
         3'd3:    t = BT_T3;
         3'd4:    t = BT_T4;
         3'd5:    t = BT_T5;
         3'd6:    t = BT_T6;
         default: t = BT_T7;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/mii_block_classifier.sv
// Combinational classifier: sorts one MII word into C/S/D/Tk/E and reports the
// terminate lane k for Tk words.
module mii_block_classifier
   import mii_pcs_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
   output blk_class_e            o_class,
   output logic [2:0]            o_term_lane
);

   logic                  w_all_idle;
   logic [CTRL_WIDTH-1:0] w_term_hit;

   always_comb begin
      logic v_match;
      w_all_idle = 1'b1;
      for (int l = 0; l < CTRL_WIDTH; l++) begin
         if (i_tx_data[8*l +: 8] != MII_IDLE) w_all_idle = 1'b0;
      end
      // Tk: data lanes below k, FD at k, idle control characters above k
      for (int k = 0; k < CTRL_WIDTH; k++) begin
         v_match = (i_tx_data[8*k +: 8] == MII_TERM);
         for (int l = 0; l < CTRL_WIDTH; l++) begin
            if (l < k) begin
               v_match = v_match & ~i_tx_ctrl[l];
            end else if (l == k) begin
               v_match = v_match & i_tx_ctrl[l];
            end else begin
               v_match = v_match & i_tx_ctrl[l] & (i_tx_data[8*l +: 8] == MII_IDLE);
            end
         end
         w_term_hit[k] = v_match;
      end
   end

   always_comb begin
      o_term_lane = 3'd0;
      for (int k = 0; k < CTRL_WIDTH; k++) begin
         if (w_term_hit[k]) o_term_lane = 3'(k);
      end
      if ((&i_tx_ctrl) && w_all_idle) begin
         o_class = BLK_C;
      end else if ((i_tx_ctrl == CTRL_WIDTH'(1)) && (i_tx_data[7:0] == MII_START)) begin
         o_class = BLK_S;
      end else if (i_tx_ctrl == '0) begin
         o_class = BLK_D;
      end else if (|w_term_hit) begin
         o_class = BLK_T;
      end else begin
         o_class = BLK_E;
      end
   end

endmodule

// File: rtl/mii_64b66b_encoder.sv
// MII to 64b/66b transmit encoder: classifies each valid word, tracks the
// transmit state machine and emits one registered 66-bit block per word.
module mii_64b66b_encoder
   import mii_pcs_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH-1:0]    i_tx_data,
   input  logic [CTRL_WIDTH-1:0]    i_tx_ctrl,
   output logic                     o_valid,
   output logic [65:0]              o_tx_coded,
   output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

   tx_state_e                r_state;
   tx_state_e                w_state_d;
   logic                     r_valid;
   logic [65:0]              r_coded;
   logic [65:0]              w_block;
   logic [55:0]              w_payload;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic                     w_is_err;
   blk_class_e               w_class;
   logic [2:0]               w_term_lane;

   mii_block_classifier #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH)
   ) u_classifier (
      .i_tx_data   (i_tx_data),
      .i_tx_ctrl   (i_tx_ctrl),
      .o_class     (w_class),
      .o_term_lane (w_term_lane)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         TX_INIT, TX_C, TX_T: begin
            if (w_class == BLK_C)      w_state_d = TX_C;
            else if (w_class == BLK_S) w_state_d = TX_D;
            else                       w_state_d = TX_E;
         end
         TX_D: begin
            if (w_class == BLK_D)      w_state_d = TX_D;
            else if (w_class == BLK_T) w_state_d = TX_T;
            else                       w_state_d = TX_E;
         end
         TX_E: begin
            if (w_class == BLK_C)      w_state_d = TX_C;
            else if (w_class == BLK_D) w_state_d = TX_D;
            else if (w_class == BLK_T) w_state_d = TX_T;
            else                       w_state_d = TX_E;
         end
         default: w_state_d = TX_E;
      endcase
   end

   always_comb begin
      w_is_err  = (w_state_d == TX_E);
      w_payload = '0;
      w_block   = {{8{CODE_IDLE}}, BT_CTRL, SYNC_CTRL};
      if (w_is_err) begin
         w_block = {{8{CODE_ERR}}, BT_CTRL, SYNC_CTRL};
      end else begin
         unique case (w_class)
            BLK_D: w_block = {i_tx_data, SYNC_DATA};
            BLK_S: w_block = {i_tx_data[63:8], BT_START, SYNC_CTRL};
            BLK_T: begin
               // pad and trailing control codes are all zero, so only data lanes matter
               for (int l = 0; l < 7; l++) begin
                  if (l < int'(w_term_lane)) w_payload[8*l +: 8] = i_tx_data[8*l +: 8];
               end
               w_block = {w_payload, term_type(w_term_lane), SYNC_CTRL};
            end
            default: w_block = {{8{CODE_IDLE}}, BT_CTRL, SYNC_CTRL};
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= TX_INIT;
         r_valid   <= 1'b0;
         r_coded   <= '0;
         r_err_cnt <= '0;
      end else if (i_valid) begin
         r_state <= w_state_d;
         r_valid <= 1'b1;
         r_coded <= w_block;
         if (w_is_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid     = r_valid;
   assign o_tx_coded  = r_coded;
   assign o_err_count = r_err_cnt;

endmodule
